// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and frame geometry.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;
    localparam int unsigned BIT_IDX_W      = $clog2(UART_DATA_BITS);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

endpackage : uart_pkg

// File: rtl/uart_rx_sync.sv
// Synchroniser for the asynchronous rxd line plus falling-edge detection.
module uart_rx_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_rxd,
    output logic o_line,
    output logic o_fall_c
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_line_d;

    // Shift rxd through the metastability chain; idle level is 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync   <= '1;
            r_line_d <= 1'b1;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], i_rxd};
            r_line_d <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_line   = r_sync[SYNC_STAGES-1];
    assign o_fall_c = ~o_line & r_line_d;

endmodule : uart_rx_sync

// File: rtl/uart_rx.sv
// 8N1 UART receiver with valid/ready output, framing-error and overrun pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 10417,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rxd,
    output logic [UART_DATA_BITS-1:0] rx_data,
    output logic                      rx_valid,
    input  logic                      rx_ready,
    output logic                      frame_err,
    output logic                      overrun,
    output logic                      busy
);

    localparam int unsigned CNT_W     = $clog2(CLKS_PER_BIT);
    localparam int unsigned HALF_BIT  = CLKS_PER_BIT / 2;
    localparam logic [CNT_W-1:0]     CNT_HALF = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0]     CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_IDX_W-1:0] IDX_LAST = BIT_IDX_W'(UART_DATA_BITS - 1);

    logic w_line;
    logic w_fall_c;

    logic [1:0]                r_state,     w_state;
    logic [CNT_W-1:0]          r_cnt,       w_cnt;
    logic [BIT_IDX_W-1:0]      r_bit_idx,   w_bit_idx;
    logic [UART_DATA_BITS-1:0] r_shift,     w_shift;
    logic [UART_DATA_BITS-1:0] r_data,      w_data;
    logic                      r_valid,     w_valid;
    logic                      r_frame_err, w_frame_err;
    logic                      r_overrun,   w_overrun;
    logic                      r_busy,      w_busy;
    logic                      r_done,      w_done;
    logic                      r_bad_stop,  w_bad_stop;

    uart_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .i_rxd    (rxd),
        .o_line   (w_line),
        .o_fall_c (w_fall_c)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_bad_stop  <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_bit_idx   <= w_bit_idx;
            r_shift     <= w_shift;
            r_data      <= w_data;
            r_valid     <= w_valid;
            r_frame_err <= w_frame_err;
            r_overrun   <= w_overrun;
            r_busy      <= w_busy;
            r_done      <= w_done;
            r_bad_stop  <= w_bad_stop;
        end
    end

    // Next-state logic: bit timing, sampling, shifting and output handshake.
    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_bit_idx   = r_bit_idx;
        w_shift     = r_shift;
        w_data      = r_data;
        w_valid     = r_valid;
        w_frame_err = 1'b0;
        w_overrun   = 1'b0;
        w_done      = 1'b0;
        w_bad_stop  = 1'b0;

        // Consumer acceptance; a byte completing now overrides the clear below.
        if (r_valid && rx_ready) begin
            w_valid = 1'b0;
        end

        // Effects of the previous cycle's stop sample.
        if (r_done) begin
            if (!r_valid || rx_ready) begin
                w_data  = r_shift;
                w_valid = 1'b1;
            end else begin
                w_overrun = 1'b1;
            end
        end
        if (r_bad_stop) begin
            w_frame_err = 1'b1;
        end

        case (r_state)
            ST_IDLE: begin
                if (w_fall_c) begin
                    w_state = ST_START;
                    w_cnt   = '0;
                end
            end
            ST_START: begin
                if (r_cnt == CNT_HALF) begin
                    w_cnt = '0;
                    if (!w_line) begin
                        w_state   = ST_DATA;
                        w_bit_idx = '0;
                    end else begin
                        w_state = ST_IDLE;
                    end
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (r_cnt == CNT_FULL) begin
                    w_cnt              = '0;
                    w_shift[r_bit_idx] = w_line;
                    if (r_bit_idx == IDX_LAST) begin
                        w_state = ST_STOP;
                    end else begin
                        w_bit_idx = r_bit_idx + BIT_IDX_W'(1);
                    end
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                if (r_cnt == CNT_FULL) begin
                    w_cnt      = '0;
                    w_state    = ST_IDLE;
                    w_done     = w_line;
                    w_bad_stop = ~w_line;
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
        endcase

        w_busy = (w_state != ST_IDLE);
    end

    assign rx_data   = r_data;
    assign rx_valid  = r_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign busy      = r_busy;

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx at 16 clocks per bit.
module tb_uart_rx;

    localparam int unsigned BIT = 16;

    logic       clk;
    logic       rst;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int total;
    int bad;

    // Event counters maintained by the monitor.
    int   n_valid;
    int   n_ferr;
    int   n_ovr;
    int   n_busy;
    logic [7:0] last_data;

    int s_valid, s_ferr, s_ovr, s_busy;

    uart_rx #(
        .CLKS_PER_BIT (BIT),
        .SYNC_STAGES  (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sample outputs on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rx_valid)  begin n_valid <= n_valid + 1; last_data <= rx_data; end
        if (frame_err) n_ferr <= n_ferr + 1;
        if (overrun)   n_ovr  <= n_ovr + 1;
        if (busy)      n_busy <= n_busy + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        @(negedge clk); #1;
        s_valid = n_valid; s_ferr = n_ferr; s_ovr = n_ovr; s_busy = n_busy;
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Drive 'periods' bit times of a frame: start, 8 data LSB first, stop.
    task automatic send_frame(input logic [7:0] d, input logic stop_b, input int periods);
        for (int p = 0; p < periods; p++) begin
            if (p == 0)      rxd = 1'b0;
            else if (p < 9)  rxd = d[p-1];
            else             rxd = stop_b;
            repeat (BIT) @(negedge clk);
        end
    endtask

    initial begin
        total = 0; bad = 0;
        n_valid = 0; n_ferr = 0; n_ovr = 0; n_busy = 0; last_data = 8'h00;
        rxd = 1'b1; rx_ready = 1'b1; rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_data",  32'(rx_data),   32'h00);
        check("rst_valid", 32'(rx_valid),  32'h0);
        check("rst_ferr",  32'(frame_err), 32'h0);
        check("rst_ovr",   32'(overrun),   32'h0);
        check("rst_busy",  32'(busy),      32'h0);
        @(negedge clk);
        rst = 1'b1;
        idle(4);

        // 0x55 with consumer ready: one valid cycle, clean flags.
        snap();
        send_frame(8'h55, 1'b1, 10);
        idle(6); #1;
        check("b55_valid_cycles", 32'(n_valid - s_valid), 32'd1);
        check("b55_data",         32'(rx_data),           32'h55);
        check("b55_ferr",         32'(n_ferr - s_ferr),   32'd0);
        check("b55_ovr",          32'(n_ovr - s_ovr),     32'd0);
        check("b55_busy_end",     32'(busy),              32'h0);

        // Short low glitch: START rejects it after half a bit.
        snap();
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        idle(24); #1;
        check("glitch_busy_cycles", 32'(n_busy - s_busy),   32'd8);
        check("glitch_valid",       32'(n_valid - s_valid), 32'd0);
        check("glitch_ferr",        32'(n_ferr - s_ferr),   32'd0);
        check("glitch_busy_end",    32'(busy),              32'h0);

        // 0xA3 with bad stop bit, then a clean 0x3C.
        snap();
        send_frame(8'hA3, 1'b0, 10);
        idle(6); #1;
        check("a3_ferr",  32'(n_ferr - s_ferr),   32'd1);
        check("a3_valid", 32'(n_valid - s_valid), 32'd0);
        snap();
        send_frame(8'h3C, 1'b1, 10);
        idle(6); #1;
        check("3c_valid_cycles", 32'(n_valid - s_valid), 32'd1);
        check("3c_data",         32'(last_data),         32'h3C);
        check("3c_ferr",         32'(n_ferr - s_ferr),   32'd0);

        // Back-to-back 0x12, 0x34 with consumer stalled: overrun once.
        rx_ready = 1'b0;
        snap();
        send_frame(8'h12, 1'b1, 10);
        send_frame(8'h34, 1'b1, 10);
        idle(6); #1;
        check("ovr_valid_held", 32'(rx_valid),         32'h1);
        check("ovr_data_held",  32'(rx_data),          32'h12);
        check("ovr_pulses",     32'(n_ovr - s_ovr),    32'd1);
        check("ovr_ferr",       32'(n_ferr - s_ferr),  32'd0);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        @(negedge clk); #1;
        check("ovr_accept_clears", 32'(rx_valid), 32'h0);
        check("ovr_data_stable",   32'(rx_data),  32'h12);

        // Reset during DATA of 0x7E: everything clears at once, no pulses.
        rx_ready = 1'b1;
        snap();
        send_frame(8'h7E, 1'b1, 5);
        check("mid_busy", 32'(busy), 32'h1);
        rst = 1'b0;
        #1;
        check("mid_rst_data",  32'(rx_data),   32'h00);
        check("mid_rst_valid", 32'(rx_valid),  32'h0);
        check("mid_rst_busy",  32'(busy),      32'h0);
        check("mid_rst_ferr",  32'(frame_err), 32'h0);
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        idle(8); #1;
        check("mid_no_ferr",  32'(n_ferr - s_ferr),   32'd0);
        check("mid_no_ovr",   32'(n_ovr - s_ovr),     32'd0);
        check("mid_no_valid", 32'(n_valid - s_valid), 32'd0);

        // Clean 0xF0 after reset release.
        snap();
        send_frame(8'hF0, 1'b1, 10);
        idle(6); #1;
        check("f0_valid_cycles", 32'(n_valid - s_valid), 32'd1);
        check("f0_data",         32'(rx_data),           32'hF0);
        check("f0_ferr",         32'(n_ferr - s_ferr),   32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_uart_rx
